nanci_row_drain: RTL
====================

# nanci_row_drain

Downstream collector for one row of Nanci processing elements. When the controller pulses capture, it snapshots the `o_PE` word of every PE in the row. It then streams those words out one per handshake over a valid/ready interface, tagged with column index and last-flag. It feeds the host readback path so results leave the mesh without stalling the PEs.

## Interface
- `N_COLS`, default 4: PEs per row (SQRT_N of the mesh), ≥1.
- `ADDR_WIDTH`, default 3: address field width of a PE word.
- `DATA_WIDTH`, default 3: data field width of a PE word.
- Derived `W = ADDR_WIDTH+DATA_WIDTH`.
- Derived `CW = max(1, $clog2(N_COLS))`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_capture` in 1: snapshot request, single-cycle pulse.
- `i_PE_row` in N_COLS*W: concatenated PE outputs; column c occupies bits [c*W +: W].
- `i_ready` in 1: consumer ready.
- `o_valid` out 1: `o_word` valid.
- `o_word` out W (W+1 with parity): current column word; `{addr,data}` in the low W bits.
- `o_col` out CW: column index of `o_word`.
- `o_last` out 1: high with `o_valid` when `o_col == N_COLS-1`.
- `o_busy` out 1: drain in progress.
- `o_overrun` out 1: sticky, capture arrived while busy.

## Operation
- States: IDLE and DRAIN.
- Reset values: state IDLE; snapshot buffer, `o_word`, `o_col` and all flags 0.
- IDLE:
  - `i_capture`=1 latches all N_COLS words into the buffer and sets col=0.
  - Enters DRAIN.
- DRAIN:
  - `o_valid`=1 and `o_busy`=1.
  - `o_word`=buf[col]; `o_col`=col.
- Handshake is `o_valid & i_ready`:
  - If col<N_COLS-1: col increments.
  - If col==N_COLS-1: return to IDLE.
- Outputs hold stable while `o_valid & ~i_ready`. The buffer is never modified during DRAIN.
- `i_capture` in DRAIN:
  - Not on the final handshake: the capture is ignored and `o_overrun` is set.
  - On the final-handshake cycle: the capture is accepted. The new snapshot is latched, col=0 and the block stays in DRAIN, giving back-to-back rows with no bubble. `o_overrun` is not set.
- `o_overrun` clears only on reset.
- N_COLS=1: each capture gives exactly one word with `o_last`=1.
- Reset asserted mid-drain: the drain is abandoned immediately, outputs go to reset values and there is no partial flush.

## Timing
- Capture at edge k: `o_valid`, `o_col`=0 and `o_word`=col 0 are visible after edge k (same cycle as `o_busy`).
- Accepted handshake at edge k: the next column is presented after edge k.
- With `i_ready` held high, a row drains in N_COLS cycles.
- After the final handshake with no new capture, `o_valid` and `o_busy` are 0 in the next cycle.
- All outputs are registered; there is no combinational path from `i_ready` or `i_capture` to any output.

## Configuration
- `NANCI_DRAIN_PARITY_EN` defined:
  - `o_word` is W+1 bits; bit W is even parity over bits [W-1:0], computed at capture and stored per column.
- Undefined: `o_word` is exactly W bits and there is no parity logic.

## Structure
- Package `nanci_pkg` holds:
  - state enum `drain_state_t` {IDLE, DRAIN};
  - function `pe_word_w(addr_w, data_w)`;
  - parity helper function.
- No sub-module. Buffer, column counter and FSM live in one module.

## Test plan
- Defaults, row = {6'b000_100, 6'b000_011, 6'b000_010, 6'b000_001} (col3..col0), `i_ready`=1, capture pulse:
  - 4 consecutive words 1,2,3,4 with `o_col` 0..3;
  - `o_last` only on 4;
  - `o_valid` low the following cycle.
- Same row, `i_ready` low for 3 cycles while `o_col`=1 → `o_word` held at 2 throughout; then 3, 4 follow.
- Capture during `o_col`=1 → `o_overrun`=1 (sticky); drain still yields the original 1..4.
- Second capture (row words 5..8) on the final-handshake cycle → 1,2,3,4,5,6,7,8 stream with no gap; `o_overrun` stays 0.
- Reset pulsed low while `o_col`=2 → `o_valid`, `o_busy`, `o_col`, `o_word` go 0 asynchronously; next capture restarts at col 0.
- With `NANCI_DRAIN_PARITY_EN`:
  - word 6'b000_011 → `o_word[6]`=0;
  - word 6'b000_001 → `o_word[6]`=1.

Source files
------------

// File: rtl/nanci_pkg.sv
// nanci_pkg: shared types and helpers for the Nanci row drain collector.
package nanci_pkg;
   typedef enum logic {IDLE, DRAIN} drain_state_t;
   function automatic int pe_word_w(input int addr_w, input int data_w);
      return addr_w + data_w;
   endfunction
   // Even parity: the returned bit makes the total count of ones even.
   function automatic logic even_par(input logic [63:0] v);
      return ^v;
   endfunction
endpackage

// File: rtl/nanci_row_drain.sv
// nanci_row_drain: snapshots one PE row on capture and streams it out over valid/ready.
// Optional NANCI_DRAIN_PARITY_EN appends a stored even-parity bit to each word.
module nanci_row_drain
   import nanci_pkg::*;
#(
   parameter int N_COLS = 4,
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 3,
   localparam int W = pe_word_w(ADDR_WIDTH, DATA_WIDTH),
   localparam int CW = N_COLS > 1 ? $clog2(N_COLS) : 1,
`ifdef NANCI_DRAIN_PARITY_EN
   localparam int OW = W + 1
`else
   localparam int OW = W
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_capture,
   input  logic [N_COLS*W-1:0] i_PE_row,
   input  logic                i_ready,
   output logic                o_valid,
   output logic [OW-1:0]       o_word,
   output logic [CW-1:0]       o_col,
   output logic                o_last,
   output logic                o_busy,
   output logic                o_overrun
);
   localparam logic [CW-1:0] LAST = CW'(N_COLS - 1);
   drain_state_t state;
   logic [OW-1:0] snap [N_COLS];
   logic [OW-1:0] cap_word [N_COLS];
   logic [CW-1:0] nxt;
   logic fin, load;
   for (genvar c = 0; c < N_COLS; c++) begin : g_cap
`ifdef NANCI_DRAIN_PARITY_EN
      assign cap_word[c] = {even_par(64'(i_PE_row[c*W +: W])), i_PE_row[c*W +: W]};
`else
      assign cap_word[c] = i_PE_row[c*W +: W];
`endif
   end
   always_comb begin
      nxt = o_col + 1'b1;
      fin = state == DRAIN && i_ready && o_col == LAST;
      load = i_capture && (state == IDLE || fin);
   end
   // o_col doubles as the column counter, so every output stays registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         snap <= '{default: '0};
         o_valid <= 1'b0;
         o_word <= '0;
         o_col <= '0;
         o_last <= 1'b0;
         o_busy <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (load) begin
            state <= DRAIN;
            snap <= cap_word;
            o_valid <= 1'b1;
            o_busy <= 1'b1;
            o_col <= '0;
            o_word <= cap_word[0];
            o_last <= N_COLS == 1;
         end else if (fin) begin
            state <= IDLE;
            o_valid <= 1'b0;
            o_busy <= 1'b0;
            o_col <= '0;
            o_word <= '0;
            o_last <= 1'b0;
         end else if (state == DRAIN && i_ready) begin
            o_col <= nxt;
            o_word <= snap[nxt];
            o_last <= nxt == LAST;
         end
         if (i_capture && state == DRAIN && !fin) o_overrun <= 1'b1;
      end
   end
endmodule
